irq_tick_gen: RTL and testbench

- Programmable periodic interrupt source driving the MicroBlaze MCS INTC_Interrupt input; replaces the free-running counter-MSB scheme.
- Produces a level request that is held until the MCS acknowledges it via INTC_IRQ (rising edge).
- Counts ticks that arrive while a request is outstanding (overruns) and a running tick total, both readable over MCS GPI.
- Period, enable and overrun clear come from MCS GPO bits.

---
 rtl/irq_tick_pkg.sv | 10 +
 rtl/edge_det.sv | 11 +
 rtl/irq_tick_gen.sv | 89 ++++++++
 tb/tb_irq_tick_gen.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/irq_tick_pkg.sv
// irq_tick_pkg: shared FSM encoding and limits for the periodic interrupt generator
package irq_tick_pkg;
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_REQ   = 2'd2,
    S_HOLD  = 2'd3
  } state_t;
  localparam int MIN_PERIOD = 2;
endpackage

// File: rtl/edge_det.sv
// edge_det: 1-bit rising-edge detector with synchronous active-low reset
module edge_det (
  input  logic clk,
  input  logic srst_n,
  input  logic i_sig,
  output logic o_rise
);
  logic r_d;
  always_ff @(posedge clk) r_d <= srst_n ? i_sig : 1'b0;
  assign o_rise = i_sig & ~r_d;
endmodule

// File: rtl/irq_tick_gen.sv
// irq_tick_gen: programmable periodic level interrupt with ack, hold-off gap and overrun counting
module irq_tick_gen
  import irq_tick_pkg::*;
#(
  parameter int CNT_W      = 27,
  parameter int DEF_PERIOD = 2**26,
  parameter int HOLD_CYC   = 4,
  parameter int OVR_W      = 8
) (
  input  logic             clk,
  input  logic             srst_n,
  input  logic             enable,
  input  logic             period_wr,
  input  logic [CNT_W-1:0] period_val,
  input  logic             ovr_clr,
  input  logic             intc_irq,
  output logic             irq_req,
  output logic [OVR_W-1:0] ovr_cnt,
  output logic [31:0]      tick_cnt,
  output logic             busy
);
  localparam int HW = HOLD_CYC > 1 ? $clog2(HOLD_CYC) : 1;
  state_t           r_state;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_cnt;
  logic [HW-1:0]    r_hold;
  logic             r_pend;
  logic [OVR_W-1:0] r_ovr;
  logic [31:0]      r_tick_cnt;
  logic             w_ack;
  logic             w_tick;
  logic             w_ovr_inc;
  logic [CNT_W-1:0] w_period_new;
  logic [OVR_W-1:0] w_ovr_base;
  edge_det u_ack (
    .clk    (clk),
    .srst_n (srst_n),
    .i_sig  (intc_irq),
    .o_rise (w_ack)
  );
  assign w_period_new = (period_val < CNT_W'(MIN_PERIOD)) ? CNT_W'(MIN_PERIOD) : period_val;
  // a period load restarts the phase, so it swallows a tick landing in the same cycle
  assign w_tick       = (r_state != S_IDLE) && (r_cnt == '0) && !period_wr;
  assign w_ovr_inc    = w_tick && (r_state == S_REQ || r_state == S_HOLD);
  assign w_ovr_base   = ovr_clr ? '0 : r_ovr;
  always_ff @(posedge clk) begin
    if (!srst_n) begin
      r_state    <= S_IDLE;
      r_period   <= CNT_W'(DEF_PERIOD);
      r_cnt      <= '0;
      r_hold     <= '0;
      r_pend     <= 1'b0;
      r_ovr      <= '0;
      r_tick_cnt <= '0;
    end else begin
      if (period_wr) r_period <= w_period_new;
      r_ovr <= (w_ovr_inc && !(&w_ovr_base)) ? w_ovr_base + 1'b1 : w_ovr_base;
      if (w_tick) r_tick_cnt <= r_tick_cnt + 32'd1;
      if (!enable) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_hold  <= '0;
        r_pend  <= 1'b0;
      end else begin
        r_cnt <= period_wr ? w_period_new - 1'b1 :
                 (r_state == S_IDLE || w_tick) ? r_period - 1'b1 : r_cnt - 1'b1;
        case (r_state)
          S_IDLE:  r_state <= S_COUNT;
          S_COUNT: if (w_tick) r_state <= S_REQ;
          S_REQ: if (w_ack) begin
            r_state <= S_HOLD;
            r_hold  <= HW'(HOLD_CYC - 1);
          end
          S_HOLD: if (r_hold == '0) begin
            r_state <= (r_pend || w_tick) ? S_REQ : S_COUNT;
            r_pend  <= 1'b0;
          end else begin
            r_hold <= r_hold - 1'b1;
            if (w_tick) r_pend <= 1'b1;
          end
        endcase
      end
    end
  end
  assign irq_req  = (r_state == S_REQ);
  assign busy     = (r_state != S_IDLE);
  assign ovr_cnt  = r_ovr;
  assign tick_cnt = r_tick_cnt;
endmodule

// File: tb/tb_irq_tick_gen.sv
// tb_irq_tick_gen: directed stimulus with a cycle model and literal checkpoints
module tb_irq_tick_gen;
  logic        clk = 0, srst_n = 0, enable = 0, period_wr = 0, ovr_clr = 0, intc_irq = 0;
  logic [26:0] period_val = '0;
  logic        irq_req, busy;
  logic [7:0]  ovr_cnt;
  logic [31:0] tick_cnt;
  int n_chk = 0, n_pass = 0, ec = 0;
  int m_period = 1 << 26, m_left = 0, m_hold = -1, m_ovr = 0, m_np;
  bit m_run = 0, m_req = 0, m_pend = 0, m_prev = 0, m_ack, m_tk;
  logic [31:0] m_ticks = '0;
  int k, low, r1, t0, t1, t2;

  irq_tick_gen dut (
    .clk        (clk),
    .srst_n     (srst_n),
    .enable     (enable),
    .period_wr  (period_wr),
    .period_val (period_val),
    .ovr_clr    (ovr_clr),
    .intc_irq   (intc_irq),
    .irq_req    (irq_req),
    .ovr_cnt    (ovr_cnt),
    .tick_cnt   (tick_cnt),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ec);
  endtask

  // model: a request is outstanding, a hold-off window is open, or the timer is just counting
  always @(posedge clk) begin
    ec++;
    if (!srst_n) begin
      m_period = 1 << 26; m_left = 0; m_hold = -1; m_run = 0; m_req = 0;
      m_pend = 0; m_prev = 0; m_ovr = 0; m_ticks = '0;
    end else begin
      m_ack  = intc_irq && !m_prev;
      m_prev = intc_irq;
      m_tk   = m_run && m_left == 0 && !period_wr;
      m_np   = period_val < 2 ? 2 : int'(period_val);
      if (period_wr) m_period = m_np;
      if (ovr_clr) m_ovr = 0;
      if (m_tk && (m_req || m_hold >= 0) && m_ovr < 255) m_ovr++;
      if (m_tk) m_ticks++;
      if (!enable) begin
        m_run = 0; m_req = 0; m_hold = -1; m_pend = 0; m_left = 0;
      end else if (!m_run) begin
        m_run = 1; m_left = m_period - 1;
      end else begin
        m_left = (period_wr || m_tk) ? m_period - 1 : m_left - 1;
        if (m_hold >= 0) begin
          if (m_hold == 0) begin m_req = m_pend || m_tk; m_pend = 0; m_hold = -1; end
          else begin m_hold--; if (m_tk) m_pend = 1; end
        end else if (m_req) begin
          if (m_ack) begin m_req = 0; m_hold = 3; end
        end else if (m_tk) m_req = 1;
      end
    end
    #1;
    chk("model_irq_req", irq_req, m_req);
    chk("model_busy", busy, m_run);
    chk("model_ovr_cnt", ovr_cnt, m_ovr);
    chk("model_tick_cnt", tick_cnt, m_ticks);
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_irq", irq_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovr", ovr_cnt, 0);
    chk("rst_ticks", tick_cnt, 0);
    srst_n = 1; enable = 1; period_wr = 1; period_val = 27'd10;
    @(negedge clk); period_wr = 0;
    k = 1;
    while (!irq_req && k < 40) begin @(negedge clk); k++; end
    chk("first_irq_cycle", k, 11);
    chk("first_tick_cnt", tick_cnt, 1);
    r1 = ec;
    repeat (4) @(negedge clk);
    intc_irq = 1;
    @(negedge clk); intc_irq = 0;
    chk("ack_drop", irq_req, 0);
    low = 1;
    while (low < 40) begin @(negedge clk); if (irq_req) break; low++; end
    chk("hold_low_cycles", low, 5);
    chk("irq_spacing", ec - r1, 10);
    repeat (35) @(negedge clk);
    chk("noack_irq", irq_req, 1);
    chk("noack_ovr", ovr_cnt, 3);
    ovr_clr = 1;
    @(negedge clk); ovr_clr = 0;
    chk("ovr_clr", ovr_cnt, 0);
    period_wr = 1; period_val = 27'd1;
    @(negedge clk); period_wr = 0;
    t0 = tick_cnt;
    repeat (20) @(negedge clk);
    chk("clamp_ticks_20cyc", tick_cnt - t0, 10);
    repeat (600) @(negedge clk);
    chk("ovr_saturate", ovr_cnt, 255);
    enable = 0;
    @(negedge clk);
    chk("dis_irq", irq_req, 0);
    chk("dis_busy", busy, 0);
    t1 = tick_cnt;
    repeat (5) @(negedge clk);
    chk("dis_ticks_kept", tick_cnt, t1);
    enable = 1; period_wr = 1; period_val = 27'd5;
    @(negedge clk); period_wr = 0;
    repeat (4) @(negedge clk);
    period_wr = 1; period_val = 27'd6; t2 = tick_cnt;
    @(negedge clk); period_wr = 0;
    chk("coinc_suppressed", tick_cnt, t2);
    repeat (5) @(negedge clk);
    chk("coinc_wait", tick_cnt, t2);
    @(negedge clk);
    chk("coinc_next_tick", tick_cnt, t2 + 1);
    chk("coinc_irq", irq_req, 1);
    period_wr = 1; period_val = 27'd3; ovr_clr = 1;
    @(negedge clk); period_wr = 0; ovr_clr = 0; intc_irq = 1;
    chk("hold_ovr_clr", ovr_cnt, 0);
    @(negedge clk); intc_irq = 0;
    chk("hold_enter", irq_req, 0);
    repeat (2) @(negedge clk);
    chk("hold_tick_ovr", ovr_cnt, 1);
    chk("hold_tick_noirq", irq_req, 0);
    @(negedge clk);
    chk("hold_last", irq_req, 0);
    @(negedge clk);
    chk("hold_exit_pend", irq_req, 1);
    srst_n = 0;
    @(negedge clk);
    chk("midrst_irq", irq_req, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ovr", ovr_cnt, 0);
    chk("midrst_ticks", tick_cnt, 0);
    srst_n = 1; enable = 0;
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
